data_ram_responder: RTL and testbench



---
 rtl/data_ram_responder.sv | 159 +++++++++++++++
 tb/tb_data_ram_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// data_ram_responder: single-port word RAM behind a CPU data bus with a
// fixed, parameterised access latency. A request is accepted in IDLE and
// held for LATENCY BUSY cycles. The access happens on the BUSY->DONE edge,
// and DONE is shown for one cycle. Error conditions set a sticky flag:
// simultaneous read+write, a misaligned address, or an address beyond the RAM.
// Optional feature macro: DATA_RAM_BYTEEN_EN (honour per-lane byte enables).
module data_ram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_waitrequest,
  output logic        error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_rd;
  logic              r_wr;
  logic              w_req;
  logic              w_wait;
  logic              w_accept;
  logic              w_access;
  logic [ADDR_W-1:0] w_idx;
  logic              w_misalign;
  logic              w_oor;
  logic              w_err_cond;
  logic [3:0]        w_lanes;
  logic [31:0]       r_mem [(1 << ADDR_W)];

  assign w_req      = data_read | data_write;
  assign w_idx      = r_addr[ADDR_W+1:2];
  assign w_misalign = |r_addr[1:0];
  // Any address bit above the RAM's byte range makes the access out of range.
  assign w_oor      = |(r_addr >> (ADDR_W + 2));
  assign w_err_cond = (r_rd & r_wr) | w_misalign | w_oor;

`ifdef DATA_RAM_BYTEEN_EN
  assign w_lanes = r_be;
`else
  // Enables are still latched but forced on, so every write covers the whole word.
  assign w_lanes = r_be | 4'hF;
`endif

  // Waitrequest is never asserted while the block is held in reset.
  assign data_waitrequest = w_wait & reset;

  // Next-state, counter and waitrequest decode for the IDLE/BUSY/DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wait      = 1'b0;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_wait      = 1'b1;
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_wait = 1'b1;
        if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_be    <= 4'h0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= data_address;
      r_wdata <= data_writedata;
      r_be    <= data_byteenable;
      r_rd    <= data_read;
      r_wr    <= data_write;
    end
  end

  // Read data register: updated only by a completed read (a read+write is a write).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_readdata <= 32'h0;
    end else if (w_access && r_rd && !r_wr) begin
      data_readdata <= w_oor ? 32'h0 : r_mem[w_idx];
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if (w_access && w_err_cond) begin
      error <= 1'b1;
    end
  end

  // RAM array: not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_access && r_wr && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Testbench for data_ram_responder: two instances (LATENCY=2 and LATENCY=1),
// a reference model of the RAM and error rules, a scoreboard queue per
// instance and a monitor that checks each completed transaction.
module tb_data_ram_responder;

  localparam int AW   = 10;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [3:0]  be    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        wreq  [2];
  logic        err   [2];

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_W(AW), .LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(reset), .data_address(addr[0]), .data_read(rd[0]),
    .data_write(wr[0]), .data_byteenable(be[0]), .data_writedata(wdata[0]),
    .data_readdata(rdata[0]), .data_waitrequest(wreq[0]), .error(err[0])
  );

  data_ram_responder #(.ADDR_W(AW), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset), .data_address(addr[1]), .data_read(rd[1]),
    .data_write(wr[1]), .data_byteenable(be[1]), .data_writedata(wdata[1]),
    .data_readdata(rdata[1]), .data_waitrequest(wreq[1]), .error(err[1])
  );

  typedef struct {
    bit          chk;
    logic [31:0] rdata;
    logic        err;
    int          wcyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mem_m   [2][1024];
  bit          known_m [2][1024];
  logic        err_m   [2];
  logic [31:0] last_rd [2];
  bit          last_chk[2];
  int          cnt     [2];
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      err_m[d]    = 1'b0;
      last_rd[d]  = 32'h0;
      last_chk[d] = 1'b1;
    end
  endtask

  // Monitor: counts waitrequest-high cycles; a high->low change is a completion.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset !== 1'b1) begin
        cnt[d] = 0;
      end else if (wreq[d] === 1'b1) begin
        cnt[d]++;
      end else if (cnt[d] > 0) begin
        if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion dut=%0d actual=done required=none", d);
        end else begin
          mon_e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("wait_cycles_dut%0d", d), cnt[d], mon_e.wcyc);
          check($sformatf("error_dut%0d", d), {31'h0, err[d]}, {31'h0, mon_e.err});
          if (mon_e.chk) check($sformatf("readdata_dut%0d", d), rdata[d], mon_e.rdata);
        end
        cnt[d] = 0;
      end
    end
  end

  // Apply the model's rules for one transaction and queue the expected outcome.
  task automatic model_txn(input int d, input bit r, input bit w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] wd);
    exp_t           e;
    logic [AW-1:0]  idx;
    logic [3:0]     beff;
    bit             inr;
    idx = a[AW+1:2];
    inr = ((a >> (AW + 2)) == 32'h0);
`ifdef DATA_RAM_BYTEEN_EN
    beff = b;
`else
    beff = 4'hF;
`endif
    if ((r && w) || (a[1:0] != 2'b00) || !inr) err_m[d] = 1'b1;
    if (w) begin
      if (inr) begin
        for (int i = 0; i < 4; i++)
          if (beff[i]) mem_m[d][idx][8*i +: 8] = wd[8*i +: 8];
        if (beff == 4'hF) known_m[d][idx] = 1'b1;
      end
    end else if (r) begin
      if (!inr) begin
        last_rd[d]  = 32'h0;
        last_chk[d] = 1'b1;
      end else begin
        last_rd[d]  = mem_m[d][idx];
        last_chk[d] = known_m[d][idx];
      end
    end
    e.chk   = last_chk[d];
    e.rdata = last_rd[d];
    e.err   = err_m[d];
    e.wcyc  = ((d == 0) ? LAT0 : LAT1) + 1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Drive one transaction; inputs are scrambled right after acceptance.
  task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] wd);
    int n;
    model_txn(d, r, w, a, b, wd);
    @(posedge clk); #1;
    addr[d] = a; rd[d] = r; wr[d] = w; be[d] = b; wdata[d] = wd;
    @(posedge clk); #1;
    addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wreq[d] !== 1'b0 && n < 40);
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout dut=%0d actual=stuck required=done", d);
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  b;
    int          d, op, kind, w;
    logic [31:0] exp_w4;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 32'h0; rd[i] = 1'b0; wr[i] = 1'b0; be[i] = 4'h0; wdata[i] = 32'h0;
      cnt[i] = 0;
    end
    model_reset();

    // Reset: outputs cleared and waitrequest low even with requests present.
    rd[0] = 1'b1; wr[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait0", {31'h0, wreq[0]}, 32'h0);
    check("rst_wait1", {31'h0, wreq[1]}, 32'h0);
    check("rst_rdata0", rdata[0], 32'h0);
    check("rst_err0", {31'h0, err[0]}, 32'h0);
    check("rst_rdata1", rdata[1], 32'h0);
    check("rst_err1", {31'h0, err[1]}, 32'h0);
    rd[0] = 1'b0; wr[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Full write then read back.
    txn(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn(0, 1, 0, 32'h10, 4'hF, 32'h0);
    check("rd_deadbeef", rdata[0], 32'hDEADBEEF);
    check("no_err_clean", {31'h0, err[0]}, 32'h0);

    // Partial-lane write.
    txn(0, 0, 1, 32'h10, 4'b0101, 32'h11223344);
    txn(0, 1, 0, 32'h10, 4'hF, 32'h0);
`ifdef DATA_RAM_BYTEEN_EN
    check("rd_byteen", rdata[0], 32'hDE22BE44);
`else
    check("rd_byteen", rdata[0], 32'h11223344);
`endif

    // Write with no lanes enabled.
    txn(0, 0, 1, 32'h10, 4'b0000, 32'hFFFFFFFF);
    txn(0, 1, 0, 32'h10, 4'hF, 32'h0);
`ifdef DATA_RAM_BYTEEN_EN
    check("rd_be0", rdata[0], 32'hDE22BE44);
`else
    check("rd_be0", rdata[0], 32'hFFFFFFFF);
`endif
    exp_w4 = rdata[0];

    // Misaligned read hits word 4, then out-of-range read returns zero.
    txn(0, 1, 0, 32'h13, 4'hF, 32'h0);
    check("misalign_err", {31'h0, err[0]}, 32'h1);
    check("misalign_data", rdata[0], exp_w4);
    txn(0, 1, 0, 32'h10001000, 4'hF, 32'h0);
    check("oor_rd_zero", rdata[0], 32'h0);
    check("oor_err_sticky", {31'h0, err[0]}, 32'h1);

    // Read and write together performs the write.
    txn(0, 1, 1, 32'h20, 4'hF, 32'hA5A5A5A5);
    txn(0, 1, 0, 32'h20, 4'hF, 32'h0);
    check("rdwr_data", rdata[0], 32'hA5A5A5A5);

    // Reset during BUSY of a write aborts it.
    txn(0, 0, 1, 32'h30, 4'hF, 32'h0);
    @(posedge clk); #1;
    addr[0] = 32'h30; wr[0] = 1'b1; be[0] = 4'hF; wdata[0] = 32'hFFFFFFFF;
    @(posedge clk); #3;
    reset = 1'b0;
    model_reset();
    #1;
    check("abort_wait", {31'h0, wreq[0]}, 32'h0);
    check("abort_rdata", rdata[0], 32'h0);
    check("abort_err", {31'h0, err[0]}, 32'h0);
    @(negedge clk);
    wr[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    txn(0, 1, 0, 32'h30, 4'hF, 32'h0);
    check("abort_mem", rdata[0], 32'h0);

    // LATENCY=1 instance: scrambled writedata during BUSY must not matter.
    txn(1, 0, 1, 32'h40, 4'hF, 32'h13579BDF);
    txn(1, 1, 0, 32'h40, 4'hF, 32'h0);
    check("lat1_rd", rdata[1], 32'h13579BDF);

    // Randomised traffic on both instances.
    for (int t = 0; t < 160; t++) begin
      d    = int'($urandom_range(0, 1));
      w    = int'($urandom_range(0, 31));
      kind = int'($urandom_range(0, 9));
      op   = int'($urandom_range(0, 9));
      a    = 32'(w) << 2;
      if (kind == 0)      a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = a | (32'h1 << $urandom_range(12, 31));
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) b = 4'hF;
      if (op <= 4)      txn(d, 1, 0, a, b, $urandom);
      else if (op <= 8) txn(d, 0, 1, a, b, $urandom);
      else              txn(d, 1, 1, a, b, $urandom);
    end

    repeat (3) @(negedge clk);
    check("q0_drained", q0.size(), 32'h0);
    check("q1_drained", q1.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
